jk_cmd_seq: RTL and testbench
=============================

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth in entries (power of two, >= 2).
REQ-002 Parameter CNT_W, default 4: width of the repeat field.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 clear  input  1: reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1: source presents a command.
REQ-006 cmd_ready  output  1: block can accept a command this cycle.
REQ-007 cmd_op  input  2: {j,k} to drive: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 cmd_rpt  input  CNT_W: command is applied for cmd_rpt+1 consecutive cycles.
REQ-009 j  output  1: J input of the downstream JK flop (registered).
REQ-010 k  output  1: K input of the downstream JK flop (registered).
REQ-011 done  output  1: high during the final j/k cycle of each command.
REQ-012 busy  output  1: a command is issuing or queued.
REQ-013 q_model  output  1: predicted Q of the downstream JK flop (registered).

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready, and SHALL be pushed as {cmd_op, cmd_rpt} into a DEPTH-entry FIFO.
REQ-015 cmd_ready SHALL be !full, decoded from registered state only; when the FIFO is full, no push SHALL occur, even if a pop happens in the same cycle.
REQ-016 The issue FSM SHALL have two states: IDLE (j=k=0) and ISSUE (j,k = current op; remain counter active).
REQ-017 IDLE -> ISSUE on an edge where the FIFO is non-empty: pop the head, load j,k <= op, and load remain <= rpt.
REQ-018 In ISSUE with remain != 0: remain decrements, and j,k hold.
REQ-019 In ISSUE with remain == 0: done=1; on the next edge, if the FIFO is non-empty, pop and load the next command (back-to-back, no 00 gap); otherwise go to IDLE with j,k <= 00.
REQ-020 Latency: a command accepted at edge E0 into an empty, idle block SHALL drive j/k after edge E1; q_model SHALL reflect it after edge E2.
REQ-021 Simultaneous push and pop SHALL be legal when not full; occupancy is unchanged in that case.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits, so full and empty are unambiguous.
REQ-023 q_model SHALL update every edge from the current registered j,k: 00 keep, 01 to 0, 10 to 1, 11 invert.
REQ-024 busy SHALL be (state == ISSUE) || FIFO non-empty.
REQ-025 done SHALL be (state == ISSUE) && (remain == 0), and SHALL be asserted for exactly one cycle per command.
REQ-026 cmd_op and cmd_rpt SHALL be ignored when cmd_valid is low.

Reset
REQ-027 While clear is high, regardless of clk: j=0, k=0, q_model=0, state=IDLE, remain=0, and the FIFO is emptied (both pointers and count = 0).
REQ-028 After clear: cmd_ready=1, busy=0, done=0.
REQ-029 clear asserted mid-command SHALL abort that command, drop all queued commands, and produce no done pulse.
REQ-030 The first command SHALL be accepted on the first rising edge after clear deasserts.

Verification
REQ-031 Reset: clear pulsed during a toggle with 3 commands queued -> j=k=0, q_model=0, busy=0, cmd_ready=1 immediately; nothing issues afterwards.
REQ-032 Single set: op=10, rpt=0 accepted at E0 -> j,k=10 for exactly one cycle after E1 with done=1; j,k=00 after E2; q_model=1 after E2; busy=0 after E2.
REQ-033 Toggle repeat: op=11, rpt=3 -> 4 cycles of j,k=11; q_model sequence 1,0,1,0; done only in the 4th cycle.
REQ-034 Back-to-back: set rpt=0, then reset rpt=0, queued -> j,k = 10 then 01 in consecutive cycles, done high in both, q_model ends at 0.
REQ-035 Full: hold with rpt=15 issuing, cmd_valid held high -> 4 more commands accepted, then cmd_ready=0 and the next command is not accepted; cmd_ready returns to 1 the cycle after the next pop.
REQ-036 Wrap: 10 commands streamed through DEPTH=4 with random valid gaps -> j/k order and durations match the input order exactly, with no loss or duplication.

Source files
------------

// File: rtl/jk_cmd_seq_if.sv
// Command handshake between a command source and the JK command sequencer.
// A command transfers on a rising edge where cmd_valid && cmd_ready; op/rpt are don't-care while cmd_valid is low.
interface jk_cmd_seq_if #(
   parameter int CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_rpt;

   modport master (output cmd_valid, output cmd_op, output cmd_rpt, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_rpt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_seq.sv
// Queues {op,rpt} commands and drives a downstream JK flop's j/k for rpt+1 cycles each,
// while keeping a registered prediction of that flop's Q.
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         clear,
   jk_cmd_seq_if.slave  cmd,
   output logic         j,
   output logic         k,
   output logic         done,
   output logic         busy,
   output logic         q_model
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] remain_q;
   logic             j_q, k_q, qm_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic [CNT_W+1:0] mem_q [DEPTH];
   logic [CNT_W+1:0] head;
   logic             full, empty, push, pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = cmd.cmd_valid && !full;
   // A pop happens when the issuer is free now or finishing its last cycle.
   assign pop   = !empty && ((state_q == IDLE) || (remain_q == '0));
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (!push && pop) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_rpt};
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= IDLE;
         remain_q <= '0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         qm_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

         case ({j_q, k_q})
            2'b01:   qm_q <= 1'b0;
            2'b10:   qm_q <= 1'b1;
            2'b11:   qm_q <= ~qm_q;
            default: qm_q <= qm_q;
         endcase

         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q      <= ISSUE;
                  {j_q, k_q}   <= head[CNT_W+1:CNT_W];
                  remain_q     <= head[CNT_W-1:0];
               end
            end
            ISSUE: begin
               if (remain_q != '0) begin
                  remain_q <= remain_q - CNT_W'(1);
               end else if (pop) begin
                  {j_q, k_q}   <= head[CNT_W+1:CNT_W];
                  remain_q     <= head[CNT_W-1:0];
               end else begin
                  state_q    <= IDLE;
                  {j_q, k_q} <= 2'b00;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd.cmd_ready = !full;
   assign j       = j_q;
   assign k       = k_q;
   assign q_model = qm_q;
   assign done    = (state_q == ISSUE) && (remain_q == '0);
   assign busy    = (state_q == ISSUE) || !empty;
endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed scenarios plus randomized streams, checked every cycle
// against a queue-based model that expands each accepted command into rpt+1 j/k cycles.
module tb_jk_cmd_seq;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic clear;
   logic j, k, done, busy, q_model;

   jk_cmd_seq_if #(.CNT_W(CNT_W)) cmd_if ();

   jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .clear   (clear),
      .cmd     (cmd_if.slave),
      .j       (j),
      .k       (k),
      .done    (done),
      .busy    (busy),
      .q_model (q_model)
   );

   always #5 clk = ~clk;

   // Model: pending commands, and the per-cycle j/k values still to be driven.
   logic [CNT_W+1:0] m_fifo[$];
   logic [1:0]       m_iss[$];
   logic             m_q;
   int               n_chk = 0;
   int               n_pass = 0;
   int               n_acc = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_iss.delete();
      m_q = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] rpt);
      logic [1:0]       cur;
      logic             acc, was_last;
      logic [CNT_W+1:0] c;
      acc = v && (m_fifo.size() < DEPTH);
      cur = (m_iss.size() > 0) ? m_iss[0] : 2'b00;
      case (cur)
         2'b01: m_q = 1'b0;
         2'b10: m_q = 1'b1;
         2'b11: m_q = ~m_q;
         default: ;
      endcase
      was_last = (m_iss.size() <= 1);
      if (m_iss.size() > 0) void'(m_iss.pop_front());
      if (was_last && m_fifo.size() > 0) begin
         c = m_fifo.pop_front();
         for (int i = 0; i <= int'(c[CNT_W-1:0]); i++) m_iss.push_back(c[CNT_W+1:CNT_W]);
      end
      if (acc) begin
         m_fifo.push_back({op, rpt});
         n_acc++;
      end
   endtask

   task automatic check_all(input string tag);
      logic [1:0] ejk;
      ejk = (m_iss.size() > 0) ? m_iss[0] : 2'b00;
      chk({tag, "_jk"},    {6'd0, j, k},          {6'd0, ejk});
      chk({tag, "_done"},  {7'd0, done},          {7'd0, m_iss.size() == 1});
      chk({tag, "_busy"},  {7'd0, busy},          {7'd0, (m_iss.size() > 0) || (m_fifo.size() > 0)});
      chk({tag, "_ready"}, {7'd0, cmd_if.cmd_ready}, {7'd0, m_fifo.size() < DEPTH});
      chk({tag, "_q"},     {7'd0, q_model},       {7'd0, m_q});
   endtask

   // Called just after a falling edge: drive, take the rising edge, check at the next falling edge.
   task automatic step(input string tag, input logic v, input logic [1:0] op, input logic [CNT_W-1:0] rpt);
      cmd_if.cmd_valid = v;
      cmd_if.cmd_op    = v ? op  : 2'($urandom_range(0, 3));
      cmd_if.cmd_rpt   = v ? rpt : CNT_W'($urandom_range(0, 15));
      @(posedge clk);
      model_edge(cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_rpt);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 2'b00, '0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (((m_iss.size() > 0) || (m_fifo.size() > 0)) && n < 400) begin
         step(tag, 1'b0, 2'b00, '0);
         n++;
      end
      idle(tag, 2);
   endtask

   initial begin
      int target;
      clear = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_rpt   = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset_held");
      clear = 1'b0;
      #1 check_all("reset_after");

      // Single set, rpt=0.
      step("set_acc", 1'b1, 2'b10, 4'd0);
      idle("set", 4);

      // Back-to-back set then reset.
      step("b2b_acc0", 1'b1, 2'b10, 4'd0);
      step("b2b_acc1", 1'b1, 2'b01, 4'd0);
      idle("b2b", 4);
      chk("b2b_q_end", {7'd0, q_model}, 8'd0);

      // Toggle repeated four times starting from q=0.
      step("tog_acc", 1'b1, 2'b11, 4'd3);
      idle("tog", 7);

      // Fill the FIFO behind a long hold command.
      step("full_acc", 1'b1, 2'b00, 4'd15);
      for (int i = 0; i < 8; i++)
         step("full_push", 1'b1, 2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 1)));
      chk("full_ready_low", {7'd0, cmd_if.cmd_ready}, 8'd0);
      for (int i = 0; i < 12; i++)
         step("full_hold", 1'b1, 2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 1)));
      drain("full_drain");

      // Wrap: 10 commands with random valid gaps.
      target = n_acc + 10;
      for (int i = 0; i < 300 && n_acc < target; i++)
         step("wrap", ($urandom_range(0, 2) != 0) && (n_acc < target),
              2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 3)));
      chk("wrap_count", 8'(n_acc), 8'(target));
      drain("wrap_drain");

      // Clear mid-toggle with three commands queued.
      step("clr_acc0", 1'b1, 2'b11, 4'd15);
      step("clr_acc1", 1'b1, 2'b10, 4'd2);
      step("clr_acc2", 1'b1, 2'b01, 4'd2);
      step("clr_acc3", 1'b1, 2'b11, 4'd2);
      step("clr_run", 1'b0, 2'b00, '0);
      cmd_if.cmd_valid = 1'b0;
      #2 clear = 1'b1;
      #1 model_reset();
      check_all("clr_now");
      #1 clear = 1'b0;
      idle("clr_after", 6);

      // Longer random stream after clear.
      for (int i = 0; i < 200; i++)
         step("rand", $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 5)));
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
